prog_ctrl: RTL and testbench
============================

Name: prog_ctrl

Overview:
- Program sequencer and instruction decoder for the picoMips core, directly upstream of the ALU.
- Fetches instruction words from a synchronous program ROM, decodes them into the ALU control strobes and the register-file write strobes, and handles jumps, conditional branches on ACC, button waits and halt.
- Every instruction takes 2 cycles (FETCH, EXEC) except waits, which hold in EXEC.

Parameters:
- PC_W, 8, program counter / ROM address width.
- RA_W, 3, register-file address width.
- IW, 15, instruction width: op[14:11], rsel[10:8], imm[7:0].

Ports:
- Clock  in  1  system clock.
- nReset  in  1  asynchronous active-low reset.
- Instr  in  IW  ROM read data; valid the cycle after ProgAddr is presented.
- ACC  in  8  ALU accumulator, used for branch decisions.
- Button  in  1  asynchronous push button; synchronised internally.
- ProgAddr  out  PC_W  ROM address; equals PC.
- Imm  out  8  instruction imm field.
- SelImm / SelSW / SelRegData  out  1 each  ALU operand selects.
- UseACC  out  1  ALU uses ACC as an addend.
- UseMul  out  1  ALU fixed-point multiply: ACC*Imm/8.
- WE  out  1  ACC write enable.
- RegWE  out  1  register-file write enable; data written is ACC.
- RegAddr  out  RA_W  register-file address = rsel.
- Halted  out  1  high in the HALT state.

Behaviour:
- Clock and reset: one clock, Clock. Reset is asynchronous and active-low on nReset.
- Reset values: PC=0, state=FETCH, both synchroniser flops 0.
- Strobes are combinational from state and Instr. All strobes are 0 outside EXEC. Imm and RegAddr always follow Instr.
- FETCH: ProgAddr=PC, so Instr is valid next cycle. Always goes to EXEC.
- EXEC: decode op. Default action is PC<=PC+1 (wrapping 2^PC_W-1 -> 0), then go to FETCH.
  - 0 NOP: no strobes.
  - 1 LDI: WE, SelImm.
  - 2 LDSW: WE, SelSW.
  - 3 LDR: WE, SelRegData.
  - 4 ADDI: WE, UseACC, SelImm.
  - 5 ADDSW: WE, UseACC, SelSW.
  - 6 ADDR: WE, UseACC, SelRegData.
  - 7 MULI: WE, UseACC, UseMul; all selects 0.
  - 8 STR: RegWE.
  - 9 JMP: PC<=imm[PC_W-1:0].
  - A BZ: if ACC==0 then PC<=imm, else PC+1.
  - B BNZ: if ACC!=0 then PC<=imm, else PC+1.
  - C WAITH: if btn_s==1 then PC+1 and go to FETCH; else stay in EXEC with PC unchanged and no strobes.
  - D WAITL: same as WAITH but waits for btn_s==0.
  - E HALT: go to HALT; PC unchanged.
  - F reserved: treated as NOP.
- HALT: absorbing, no strobes, Halted=1. Only reset exits it.
- Branch decisions use ACC as it is during EXEC, i.e. after the previous instruction's WE edge.
- At most one of SelImm/SelSW/SelRegData is high. WE and RegWE are never both high.
- btn_s is Button after a 2-flop synchroniser, so a button change is visible 2 clock edges later.
- Reset asserted mid-EXEC: strobes drop immediately (state goes to FETCH asynchronously), so no partial write reaches the ALU/regfile edge.
- Jump to the current PC, e.g. "JMP self", is legal and loops.

Decomposition:
- Opcode constants and the state enum {FETCH, EXEC, HALT} go in the shared opcodes.sv package/include that the ALU already uses.
- Sub-module btn_sync: 2-flop synchroniser with async active-low reset to 0.
- Decoder stays in-line as a single combinational case.

Test Plan:
- Reset then ROM[0]=LDI 0x05 -> ProgAddr 0 in cycle 0; EXEC in cycle 1 with WE=1, SelImm=1, Imm=0x05, others 0; ProgAddr=1 in cycle 2.
- Sequence LDI 3; STR r2; ADDR r2; MULI 0x10 -> EXEC strobes respectively {WE,SelImm}, {RegWE,RegAddr=2}, {WE,UseACC,SelRegData}, {WE,UseACC,UseMul}; 8 cycles total.
- BZ 0x20 with ACC=0 -> next ProgAddr=0x20. With ACC=0x01 -> next ProgAddr=PC+1. BNZ gives the mirrored results.
- WAITH with Button=0 for 10 cycles, then 1 -> stays in EXEC with PC constant and no strobes; leaves EXEC exactly 2 edges after the Button rise plus 1. WAITL is checked the same way.
- PC=0xFF executing NOP -> next ProgAddr=0x00. HALT -> Halted=1 and strobes 0 for 20 cycles, then nReset low -> PC=0, Halted=0.
- nReset pulsed low during EXEC of LDI -> WE falls asynchronously; after release ProgAddr=0 and state=FETCH.

Source files
------------

// File: rtl/prog_ctrl_pkg.sv
// Shared picoMips sequencer definitions: FSM state codes, opcode map and the
// opcode-to-strobe decode helper used by the program controller.
package prog_ctrl_pkg;

    localparam int PC_W_DEF = 8;
    localparam int RA_W_DEF = 3;
    localparam int IW_DEF   = 15;

    // Sequencer states
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Opcodes, instruction bits [14:11]
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LDSW  = 4'h2;
    localparam logic [3:0] OP_LDR   = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_ADDSW = 4'h5;
    localparam logic [3:0] OP_ADDR  = 4'h6;
    localparam logic [3:0] OP_MULI  = 4'h7;
    localparam logic [3:0] OP_STR   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_BZ    = 4'hA;
    localparam logic [3:0] OP_BNZ   = 4'hB;
    localparam logic [3:0] OP_WAITH = 4'hC;
    localparam logic [3:0] OP_WAITL = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hE;
    localparam logic [3:0] OP_RSVD  = 4'hF;

    // ALU / register-file control strobes driven during EXEC
    typedef struct packed {
        logic sel_imm;
        logic sel_sw;
        logic sel_reg;
        logic use_acc;
        logic use_mul;
        logic we;
        logic reg_we;
    } strobes_t;

    // Decode an opcode into its strobe set; control-flow ops drive nothing.
    function automatic strobes_t decode_op(input logic [3:0] op);
        strobes_t s;
        s = strobes_t'(7'b0000000);
        case (op)
            OP_LDI:   begin s.we = 1'b1; s.sel_imm = 1'b1; end
            OP_LDSW:  begin s.we = 1'b1; s.sel_sw  = 1'b1; end
            OP_LDR:   begin s.we = 1'b1; s.sel_reg = 1'b1; end
            OP_ADDI:  begin s.we = 1'b1; s.use_acc = 1'b1; s.sel_imm = 1'b1; end
            OP_ADDSW: begin s.we = 1'b1; s.use_acc = 1'b1; s.sel_sw  = 1'b1; end
            OP_ADDR:  begin s.we = 1'b1; s.use_acc = 1'b1; s.sel_reg = 1'b1; end
            OP_MULI:  begin s.we = 1'b1; s.use_acc = 1'b1; s.use_mul = 1'b1; end
            OP_STR:   begin s.reg_we = 1'b1; end
            default:  begin s = strobes_t'(7'b0000000); end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/prog_ctrl_btn_sync.sv
// Two-flop synchroniser bringing the asynchronous push button into the Clock
// domain; both stages clear to 0 on reset.
module prog_ctrl_btn_sync (
    input  logic Clock,
    input  logic nReset,
    input  logic Button,
    output logic ButtonSync
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the raw button level
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= Button;
            sync_r <= meta_r;
        end
    end

    assign ButtonSync = sync_r;

endmodule

// File: rtl/prog_ctrl.sv
// picoMips program sequencer and instruction decoder. Two cycles per
// instruction (FETCH presents PC to the synchronous ROM, EXEC decodes the
// returned word); button waits hold in EXEC and HALT is absorbing.
module prog_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int RA_W = RA_W_DEF,
    parameter int IW   = IW_DEF
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic [IW-1:0]   Instr,
    input  logic [7:0]      ACC,
    input  logic            Button,
    output logic [PC_W-1:0] ProgAddr,
    output logic [7:0]      Imm,
    output logic            SelImm,
    output logic            SelSW,
    output logic            SelRegData,
    output logic            UseACC,
    output logic            UseMul,
    output logic            WE,
    output logic            RegWE,
    output logic [RA_W-1:0] RegAddr,
    output logic            Halted
);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] jmp_tgt_s;
    logic [3:0]      op_s;
    logic            btn_s;
    strobes_t        strb_s;

    prog_ctrl_btn_sync u_btn_sync (
        .Clock      (Clock),
        .nReset     (nReset),
        .Button     (Button),
        .ButtonSync (btn_s)
    );

    assign op_s      = Instr[IW-1 -: 4];
    assign jmp_tgt_s = Instr[PC_W-1:0];
    assign pc_inc_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

    assign ProgAddr  = pc_r;
    assign Imm       = Instr[7:0];
    assign RegAddr   = Instr[8 +: RA_W];
    assign Halted    = (state_r == ST_HALT);

    // Next state and next PC; PC only moves when an EXEC completes
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        case (state_r)
            ST_FETCH: begin
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt_s = ST_FETCH;
                pc_nxt_s    = pc_inc_s;
                case (op_s)
                    OP_JMP: begin
                        pc_nxt_s = jmp_tgt_s;
                    end
                    OP_BZ: begin
                        if (ACC == 8'h00) pc_nxt_s = jmp_tgt_s;
                        else              pc_nxt_s = pc_inc_s;
                    end
                    OP_BNZ: begin
                        if (ACC != 8'h00) pc_nxt_s = jmp_tgt_s;
                        else              pc_nxt_s = pc_inc_s;
                    end
                    OP_WAITH: begin
                        if (btn_s) begin
                            state_nxt_s = ST_FETCH;
                            pc_nxt_s    = pc_inc_s;
                        end else begin
                            state_nxt_s = ST_EXEC;
                            pc_nxt_s    = pc_r;
                        end
                    end
                    OP_WAITL: begin
                        if (!btn_s) begin
                            state_nxt_s = ST_FETCH;
                            pc_nxt_s    = pc_inc_s;
                        end else begin
                            state_nxt_s = ST_EXEC;
                            pc_nxt_s    = pc_r;
                        end
                    end
                    OP_HALT: begin
                        state_nxt_s = ST_HALT;
                        pc_nxt_s    = pc_r;
                    end
                    default: begin
                        state_nxt_s = ST_FETCH;
                        pc_nxt_s    = pc_inc_s;
                    end
                endcase
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
                pc_nxt_s    = pc_r;
            end
            default: begin
                state_nxt_s = ST_FETCH;
                pc_nxt_s    = pc_r;
            end
        endcase
    end

    // Sequencer state and program counter
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r <= ST_FETCH;
            pc_r    <= {PC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Strobes only in EXEC so an async reset drops them immediately
    always_comb begin
        strb_s = strobes_t'(7'b0000000);
        if (state_r == ST_EXEC) begin
            strb_s = decode_op(op_s);
        end else begin
            strb_s = strobes_t'(7'b0000000);
        end
    end

    assign SelImm     = strb_s.sel_imm;
    assign SelSW      = strb_s.sel_sw;
    assign SelRegData = strb_s.sel_reg;
    assign UseACC     = strb_s.use_acc;
    assign UseMul     = strb_s.use_mul;
    assign WE         = strb_s.we;
    assign RegWE      = strb_s.reg_we;

endmodule

// File: tb/tb_prog_ctrl.sv
// Self-checking bench for prog_ctrl: a synchronous ROM model feeds the DUT and
// an instruction-level model tracks the expected PC and strobes.
module tb_prog_ctrl;

    logic        Clock;
    logic        nReset;
    logic [14:0] Instr;
    logic [7:0]  ACC;
    logic        Button;
    logic [7:0]  ProgAddr;
    logic [7:0]  Imm;
    logic        SelImm, SelSW, SelRegData, UseACC, UseMul, WE, RegWE;
    logic [2:0]  RegAddr;
    logic        Halted;

    logic [14:0] rom [256];
    logic [7:0]  pc_m;
    int          checks;
    int          failures;
    logic [6:0]  strb;

    assign strb = {SelImm, SelSW, SelRegData, UseACC, UseMul, WE, RegWE};

    prog_ctrl dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .Instr      (Instr),
        .ACC        (ACC),
        .Button     (Button),
        .ProgAddr   (ProgAddr),
        .Imm        (Imm),
        .SelImm     (SelImm),
        .SelSW      (SelSW),
        .SelRegData (SelRegData),
        .UseACC     (UseACC),
        .UseMul     (UseMul),
        .WE         (WE),
        .RegWE      (RegWE),
        .RegAddr    (RegAddr),
        .Halted     (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous program ROM: data valid the cycle after the address
    always @(posedge Clock) Instr <= rom[ProgAddr];

    function automatic logic [14:0] mk(input logic [3:0] op, input logic [2:0] rs, input logic [7:0] imm);
        return {op, rs, imm};
    endfunction

    // Strobe set per opcode, bit order {SelImm,SelSW,SelRegData,UseACC,UseMul,WE,RegWE}
    function automatic logic [6:0] exp_strobes(input logic [3:0] op);
        case (op)
            4'h1: return 7'b1000010;
            4'h2: return 7'b0100010;
            4'h3: return 7'b0010010;
            4'h4: return 7'b1001010;
            4'h5: return 7'b0101010;
            4'h6: return 7'b0011010;
            4'h7: return 7'b0001110;
            4'h8: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply reset and return at the first FETCH negedge with PC=0
    task automatic do_reset();
        @(negedge Clock);
        nReset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        pc_m = 8'h00;
    endtask

    // One FETCH+EXEC instruction starting at a FETCH negedge
    task automatic do_instr(input logic [7:0] acc_v);
        logic [14:0] iw;
        logic [3:0]  op;
        chk("fetch_addr", {24'd0, ProgAddr}, {24'd0, pc_m});
        chk("fetch_strb", {25'd0, strb}, 32'd0);
        ACC = acc_v;
        @(negedge Clock);
        iw = rom[pc_m];
        op = iw[14:11];
        chk("exec_strb", {25'd0, strb}, {25'd0, exp_strobes(op)});
        chk("exec_imm", {24'd0, Imm}, {24'd0, iw[7:0]});
        chk("exec_rsel", {29'd0, RegAddr}, {29'd0, iw[10:8]});
        chk("exec_halted", {31'd0, Halted}, 32'd0);
        case (op)
            4'h9:    pc_m = iw[7:0];
            4'hA:    pc_m = (acc_v == 8'h00) ? iw[7:0] : pc_m + 8'd1;
            4'hB:    pc_m = (acc_v != 8'h00) ? iw[7:0] : pc_m + 8'd1;
            default: pc_m = pc_m + 8'd1;
        endcase
        @(negedge Clock);
    endtask

    // Button wait starting at a FETCH negedge; releases on level lvl
    task automatic do_wait(input string tag, input logic lvl);
        chk({tag, "_fetch"}, {24'd0, ProgAddr}, {24'd0, pc_m});
        @(negedge Clock);
        for (int i = 0; i < 10; i++) begin
            chk({tag, "_hold_addr"}, {24'd0, ProgAddr}, {24'd0, pc_m});
            chk({tag, "_hold_strb"}, {25'd0, strb}, 32'd0);
            @(negedge Clock);
        end
        Button = lvl;
        @(negedge Clock);
        chk({tag, "_edge1"}, {24'd0, ProgAddr}, {24'd0, pc_m});
        @(negedge Clock);
        chk({tag, "_edge2"}, {24'd0, ProgAddr}, {24'd0, pc_m});
        @(negedge Clock);
        pc_m = pc_m + 8'd1;
        chk({tag, "_edge3"}, {24'd0, ProgAddr}, {24'd0, pc_m});
    endtask

    initial begin
        logic [3:0] rop;
        logic [7:0] racc;
        checks = 0;
        failures = 0;
        nReset = 1'b0;
        Button = 1'b0;
        ACC = 8'h00;
        pc_m = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 15'd0;

        // Reset state
        #12;
        chk("rst_addr", {24'd0, ProgAddr}, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd0);
        chk("rst_strb", {25'd0, strb}, 32'd0);

        // Directed program: loads, store, mul, branches, waits, wrap
        rom[8'h00] = mk(4'h1, 3'd0, 8'h05);
        rom[8'h01] = mk(4'h8, 3'd2, 8'h00);
        rom[8'h02] = mk(4'h6, 3'd2, 8'h00);
        rom[8'h03] = mk(4'h7, 3'd0, 8'h10);
        rom[8'h04] = mk(4'hA, 3'd0, 8'h20);
        rom[8'h20] = mk(4'hA, 3'd0, 8'h40);
        rom[8'h21] = mk(4'hB, 3'd0, 8'h50);
        rom[8'h22] = mk(4'hB, 3'd0, 8'h60);
        rom[8'h60] = mk(4'hC, 3'd0, 8'h00);
        rom[8'h61] = mk(4'hD, 3'd0, 8'h00);
        rom[8'h62] = mk(4'h9, 3'd0, 8'hFF);
        rom[8'hFF] = mk(4'h0, 3'd0, 8'h00);
        do_reset();
        do_instr(8'h00);
        do_instr(8'h05);
        do_instr(8'h05);
        do_instr(8'h0A);
        do_instr(8'h00);
        chk("bz_taken", {24'd0, ProgAddr}, 32'h20);
        do_instr(8'h01);
        chk("bz_not_taken", {24'd0, ProgAddr}, 32'h21);
        do_instr(8'h00);
        chk("bnz_not_taken", {24'd0, ProgAddr}, 32'h22);
        do_instr(8'h07);
        chk("bnz_taken", {24'd0, ProgAddr}, 32'h60);
        do_wait("waith", 1'b1);
        do_wait("waitl", 1'b0);
        do_instr(8'h00);
        chk("jmp_ff", {24'd0, ProgAddr}, 32'hFF);
        do_instr(8'h00);
        chk("pc_wrap", {24'd0, ProgAddr}, 32'h00);

        // Jump to self loops
        rom[8'h00] = mk(4'h9, 3'd0, 8'h00);
        do_reset();
        do_instr(8'h00);
        do_instr(8'h00);
        chk("jmp_self", {24'd0, ProgAddr}, 32'h00);

        // Random programs without waits or halt, checked by the model
        for (int i = 0; i < 256; i++) begin
            rop = 4'($urandom_range(0, 12));
            if (rop == 4'hC) rop = 4'hF;
            rom[i] = mk(rop, 3'($urandom), 8'($urandom));
        end
        do_reset();
        for (int n = 0; n < 200; n++) begin
            racc = 8'($urandom);
            if ($urandom_range(0, 3) == 0) racc = 8'h00;
            do_instr(racc);
        end

        // HALT is absorbing until reset
        rom[8'h00] = mk(4'h1, 3'd0, 8'h09);
        rom[8'h01] = mk(4'hE, 3'd0, 8'h00);
        do_reset();
        do_instr(8'h00);
        chk("halt_fetch", {24'd0, ProgAddr}, 32'h01);
        @(negedge Clock);
        chk("halt_exec_strb", {25'd0, strb}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            chk("halt_flag", {31'd0, Halted}, 32'd1);
            chk("halt_strb", {25'd0, strb}, 32'd0);
            chk("halt_addr", {24'd0, ProgAddr}, 32'h01);
        end
        #2 nReset = 1'b0;
        #1;
        chk("halt_rst_addr", {24'd0, ProgAddr}, 32'h00);
        chk("halt_rst_flag", {31'd0, Halted}, 32'd0);

        // Reset pulsed during EXEC of LDI drops WE asynchronously
        rom[8'h00] = mk(4'h1, 3'd0, 8'hAA);
        do_reset();
        chk("mid_fetch_addr", {24'd0, ProgAddr}, 32'h00);
        @(negedge Clock);
        chk("mid_we_before", {31'd0, WE}, 32'd1);
        #2 nReset = 1'b0;
        #1;
        chk("mid_we_async", {31'd0, WE}, 32'd0);
        chk("mid_addr_async", {24'd0, ProgAddr}, 32'h00);
        @(negedge Clock);
        nReset = 1'b1;
        chk("mid_rel_strb", {25'd0, strb}, 32'd0);
        chk("mid_rel_addr", {24'd0, ProgAddr}, 32'h00);
        @(negedge Clock);
        chk("mid_rel_exec_we", {31'd0, WE}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
